// File: rtl/quad_pkg.sv
// Shared types and helpers for the quadrature decoder: phase encoding,
// FSM states, synchronizer depth and the (old, new) phase classifier.
package quad_pkg;

  typedef logic [1:0] phase_t;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  typedef enum logic [1:0] {
    MV_NONE,
    MV_UP,
    MV_DOWN,
    MV_ILLEGAL
  } move_t;

  localparam int SYNC_STAGES = 2;

  // Up order is 00->10->11->01->00 (A leads B); any single-bit change that
  // is not in that order is a down step, and a two-bit change is illegal.
  function automatic move_t classify(input phase_t old_p, input phase_t new_p);
    move_t mv;
    if (old_p == new_p) begin
      mv = MV_NONE;
    end else if ((old_p ^ new_p) == 2'b11) begin
      mv = MV_ILLEGAL;
    end else begin
      case ({old_p, new_p})
        4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: mv = MV_UP;
        default:                                mv = MV_DOWN;
      endcase
    end
    return mv;
  endfunction

endpackage

// File: rtl/quad_filt.sv
// One encoder channel: a SYNC_STAGES-deep synchronizer followed by a hold
// filter that only accepts a new level after it has been seen FILT_LEN
// consecutive cycles. 'load' forces the accepted value from the synchronizer.
module quad_filt
  import quad_pkg::*;
#(
  parameter int FILT_LEN = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic d_async,
  output logic q_filt
);

  localparam logic [3:0] CNT_LAST = 4'(FILT_LEN - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_out;
  logic [3:0]             cnt;

  assign sync_out = sync_q[SYNC_STAGES-1];

  // Synchronize the pin, then count how long it has disagreed with the accepted level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      cnt    <= '0;
      q_filt <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_async};
      if (load) begin
        q_filt <= sync_out;
        cnt    <= '0;
      end else if (sync_out == q_filt) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        q_filt <= sync_out;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 4'd1;
      end
    end
  end

endmodule

// File: rtl/quad_decoder.sv
// Quadrature decoder top: two filtered channels, an init/run FSM, step
// decode with direction, and a sticky flag plus saturating counter for
// illegal two-bit phase jumps. All outputs come straight from flops.
module quad_decoder
  import quad_pkg::*;
#(
  parameter int FILT_LEN = 4,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_in,
  input  logic             b_in,
  input  logic             clr_err,
  output logic             step_en,
  output logic             step_up,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt,
  output logic [1:0]       phase
);

  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

  state_t     state;
  logic [1:0] init_cnt;
  logic       armed;
  logic       load;
  logic       a_filt;
  logic       b_filt;
  phase_t     cur_phase;
  phase_t     prev_phase;
  move_t      mv;

  // The accepted values are loaded once the synchronizers hold real pin data.
  assign load      = (state == ST_INIT) && (init_cnt == 2'(SYNC_STAGES));
  assign cur_phase = {a_filt, b_filt};
  assign phase     = cur_phase;
  assign mv        = classify(prev_phase, cur_phase);

  quad_filt #(.FILT_LEN(FILT_LEN)) u_filt_a (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load),
    .d_async(a_in),
    .q_filt (a_filt)
  );

  quad_filt #(.FILT_LEN(FILT_LEN)) u_filt_b (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load),
    .d_async(b_in),
    .q_filt (b_filt)
  );

  // FSM plus registered decode: 'armed' holds off decode for the cycle
  // after the initial load so the preloaded phase is never seen as a jump.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_INIT;
      init_cnt   <= '0;
      armed      <= 1'b0;
      prev_phase <= '0;
      step_en    <= 1'b0;
      step_up    <= 1'b0;
      err        <= 1'b0;
      err_cnt    <= '0;
    end else begin
      prev_phase <= cur_phase;
      step_en    <= 1'b0;
      step_up    <= 1'b0;
      case (state)
        ST_INIT: begin
          armed <= 1'b0;
          if (load) begin
            state <= ST_RUN;
          end else begin
            init_cnt <= init_cnt + 2'd1;
          end
        end
        ST_RUN: begin
          armed <= 1'b1;
          if (armed) begin
            step_en <= (mv == MV_UP) || (mv == MV_DOWN);
            step_up <= (mv == MV_UP);
          end
        end
        default: state <= ST_INIT;
      endcase

      if (armed && (mv == MV_ILLEGAL)) begin
        err <= 1'b1;
        if (clr_err) begin
          err_cnt <= {{(ERR_W-1){1'b0}}, 1'b1};
        end else if (err_cnt != ERR_MAX) begin
          err_cnt <= err_cnt + 1'b1;
        end
      end else if (clr_err) begin
        err     <= 1'b0;
        err_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_quad_decoder.sv
// Directed bench for quad_decoder with FILT_LEN=4, ERR_W=8. Expected steps
// (direction and arrival cycle) are queued when pins change and popped by
// a monitor whenever step_en is seen.
module tb_quad_decoder;

  logic       clk;
  logic       rst_n;
  logic       a_in;
  logic       b_in;
  logic       clr_err;
  logic       step_en;
  logic       step_up;
  logic       err;
  logic [7:0] err_cnt;
  logic [1:0] phase;

  int         cyc;
  int         passCount;
  int         failCount;
  int         checkCount;
  int         expCycle[$];
  bit         expUp[$];
  logic [1:0] benchPhase;
  logic [3:0] ctr;

  quad_decoder #(.FILT_LEN(4), .ERR_W(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .a_in   (a_in),
    .b_in   (b_in),
    .clr_err(clr_err),
    .step_en(step_en),
    .step_up(step_up),
    .err    (err),
    .err_cnt(err_cnt),
    .phase  (phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running edge count used to time-stamp pin changes and steps.
  always @(posedge clk) cyc <= cyc + 1;

  // Downstream 4-bit up/down counter fed by the step outputs.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ctr <= 4'd0;
    else if (step_en) ctr <= step_up ? ctr + 4'd1 : ctr - 4'd1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [1:0] upNext(input logic [1:0] p);
    case (p)
      2'b00:   return 2'b10;
      2'b10:   return 2'b11;
      2'b11:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  task automatic pushStep(input bit up, input int atCycle);
    expUp.push_back(up);
    expCycle.push_back(atCycle);
  endtask

  // Drive a new pin pair (called at a negedge), queue the step it should make, hold it.
  task automatic applyStimulus(input logic a, input logic b, input int hold);
    logic [1:0] nxt;
    nxt = {a, b};
    if (nxt != benchPhase && (nxt ^ benchPhase) != 2'b11)
      pushStep(nxt == upNext(benchPhase), cyc + 7);
    benchPhase = nxt;
    a_in = a;
    b_in = b;
    waitCycles(hold);
  endtask

  // Every step pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    int ec;
    bit eu;
    if (rst_n && step_en) begin
      checkOutput("step_expected", 32'(expCycle.size() != 0), 32'd1);
      if (expCycle.size() != 0) begin
        ec = expCycle.pop_front();
        eu = expUp.pop_front();
        checkOutput("step_cycle", cyc, ec);
        checkOutput("step_dir", 32'(step_up), 32'(eu));
      end
    end
  end

  initial begin
    logic [3:0] base;
    logic [3:0] diff;
    int c;
    cyc = 0;
    passCount = 0;
    failCount = 0;
    checkCount = 0;
    rst_n = 1'b0;
    a_in = 1'b1;
    b_in = 1'b1;
    clr_err = 1'b0;
    benchPhase = 2'b11;

    waitCycles(3);
    checkOutput("rst_step_en", 32'(step_en), 32'd0);
    checkOutput("rst_step_up", 32'(step_up), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    checkOutput("rst_err_cnt", 32'(err_cnt), 32'd0);
    checkOutput("rst_phase", 32'(phase), 32'd0);

    rst_n = 1'b1;
    waitCycles(6);
    checkOutput("init_phase", 32'(phase), 32'b11);
    checkOutput("init_err", 32'(err), 32'd0);

    applyStimulus(1'b0, 1'b1, 20);
    applyStimulus(1'b0, 1'b0, 20);
    checkOutput("walk_phase", 32'(phase), 32'b00);

    base = ctr;
    applyStimulus(1'b1, 1'b0, 20);
    applyStimulus(1'b1, 1'b1, 20);
    applyStimulus(1'b0, 1'b1, 20);
    applyStimulus(1'b0, 1'b0, 20);
    diff = ctr - base;
    checkOutput("ctr_up", 32'(diff), 32'd4);

    base = ctr;
    applyStimulus(1'b0, 1'b1, 20);
    applyStimulus(1'b1, 1'b1, 20);
    applyStimulus(1'b1, 1'b0, 20);
    applyStimulus(1'b0, 1'b0, 20);
    diff = ctr - base;
    checkOutput("ctr_down", 32'(diff), 32'd12);

    a_in = 1'b1;
    waitCycles(3);
    a_in = 1'b0;
    waitCycles(20);
    checkOutput("glitch3_phase", 32'(phase), 32'b00);

    c = cyc;
    a_in = 1'b1;
    pushStep(1'b1, c + 7);
    waitCycles(4);
    a_in = 1'b0;
    pushStep(1'b0, c + 11);
    waitCycles(20);
    checkOutput("glitch4_phase", 32'(phase), 32'b00);

    applyStimulus(1'b1, 1'b1, 10);
    checkOutput("illegal_err", 32'(err), 32'd1);
    checkOutput("illegal_cnt", 32'(err_cnt), 32'd1);
    for (int i = 1; i < 300; i++) applyStimulus(~benchPhase[1], ~benchPhase[0], 6);
    waitCycles(4);
    checkOutput("sat_cnt", 32'(err_cnt), 32'd255);
    checkOutput("sat_err", 32'(err), 32'd1);

    clr_err = 1'b1;
    waitCycles(1);
    clr_err = 1'b0;
    checkOutput("clr_err_flag", 32'(err), 32'd0);
    checkOutput("clr_err_cnt", 32'(err_cnt), 32'd0);

    applyStimulus(~benchPhase[1], ~benchPhase[0], 6);
    checkOutput("pre_coinc_err", 32'(err), 32'd0);
    clr_err = 1'b1;
    waitCycles(1);
    clr_err = 1'b0;
    checkOutput("coinc_err", 32'(err), 32'd1);
    checkOutput("coinc_cnt", 32'(err_cnt), 32'd1);
    waitCycles(5);

    benchPhase = 2'b01;
    a_in = 1'b0;
    b_in = 1'b1;
    waitCycles(2);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_step_en", 32'(step_en), 32'd0);
    checkOutput("midrst_phase", 32'(phase), 32'd0);
    checkOutput("midrst_err", 32'(err), 32'd0);
    checkOutput("midrst_cnt", 32'(err_cnt), 32'd0);
    waitCycles(2);
    rst_n = 1'b1;
    waitCycles(8);
    checkOutput("reinit_phase", 32'(phase), 32'(benchPhase));
    waitCycles(15);

    checkOutput("queue_drained", 32'(expCycle.size()), 32'd0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
